// File: rtl/m6809_glue_pkg.sv
// m6809_glue_pkg
// Shared types, constants and decode helpers for the 6809 bus glue
// controller: bus-cycle FSM state encoding, I/O page prefix and UART
// sub-range code, plus the select decode used at the cycle-capture edge.
package m6809_glue_pkg;

    // Bus-cycle tracker states, advanced on synchronised E edges.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_HOLD   = 2'b10
    } cyc_state_t;

    // Upper six bits of the I/O page; the low two bits come from DIP.
    localparam logic [5:0] IO_PAGE_PREFIX = 6'b111111;

    // A[7:5] code of the UART window inside the I/O page.
    localparam logic [2:0] UART_SUB_CODE = 3'b000;

    // Active-high select requests produced by the address decode.
    typedef struct packed {
        logic csio;
        logic csuart;
        logic iack;
    } sel_req_t;

    // True when the upper address byte lands in the DIP-selected I/O page.
    function automatic logic io_page_hit(input logic [7:0] a_hi, input logic [1:0] dip);
        return (a_hi == {IO_PAGE_PREFIX, dip});
    endfunction

    // Decode one bus cycle. Chip selects are suppressed while the bus is
    // granted (BA and BS both high); the two chip selects are mutually
    // exclusive because they split the page on A[7:5].
    function automatic sel_req_t decode_sel(input logic [10:0] a_15_5,
                                            input logic [1:0]  dip,
                                            input logic        ba,
                                            input logic        bs);
        sel_req_t   req;
        logic       granted;
        logic       page;
        logic [2:0] sub;
        granted    = ba & bs;
        page       = io_page_hit(a_15_5[10:3], dip) & ~granted;
        sub        = a_15_5[2:0];
        req.csuart = page & (sub == UART_SUB_CODE);
        req.csio   = page & (sub != UART_SUB_CODE);
        req.iack   = bs & ~ba;
        return req;
    endfunction

endpackage

// File: rtl/m6809_sync_edge.sv
// m6809_sync_edge
// Two-flop synchroniser for a clock-like signal that is asynchronous to
// clk, followed by a third flop used only for edge detection. The stage-2
// flop is the synchronised level; rise/fall are one-clk pulses.
module m6809_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchroniser chain plus edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= din;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign sync = s2_r;
    assign rise = s2_r & ~s3_r;
    assign fall = ~s2_r & s3_r;

endmodule

// File: rtl/m6809_glue_ctrl.sv
// m6809_glue_ctrl
// Glue logic between a 6809 CPU and the system bus, clocked by HSCLK:
//   - synchronises the CPU E and Q clocks onto HSCLK,
//   - tracks each bus cycle with an IDLE/ACTIVE/HOLD FSM on E edges,
//   - decodes UART / I/O chip selects and the interrupt acknowledge,
//   - registers bus grant acknowledge,
//   - holds the CPC bus reset for RST_STRETCH E cycles after RST_B release.
// Optional build macro M6809_A8_REMAP_EN: when defined, SYS_A8 is flipped
// during vector fetches (BS=1, BA=0) so vectors are fetched from page $FE.
module m6809_glue_ctrl
    import m6809_glue_pkg::*;
#(
    parameter int RST_STRETCH = 16
) (
    input  logic        HSCLK,
    input  logic        RST_B,
    input  logic        ECLK_LPF,
    input  logic        QCLK,
    input  logic [15:5] A,
    input  logic        BA,
    input  logic        BS,
    input  logic        RNW,
    input  logic [1:0]  DIP,
    output logic        SYS_ECLK,
    output logic        SYS_Q_AUXCLK,
    output logic        CSIO_B,
    output logic        CSUART_B,
    output logic        SYS_A8,
    output logic        IACK_B,
    output logic        BUSACK_B,
    output logic        CPC_BUSRST_B
);

    localparam int CNT_W = (RST_STRETCH < 1) ? 1 : $clog2(RST_STRETCH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RST_STRETCH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic       e_sync_s;
    logic       e_rise_s;
    logic       e_fall_s;
    logic       q_sync_s;
    logic       q_rise_s;
    logic       q_fall_s;
    logic       sink_unused_s;

    cyc_state_t state_r;
    logic       pend_rise_r;
    logic       csio_r;
    logic       csuart_r;
    logic       iack_r;
    logic       busack_r;
    logic       busrst_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    sel_req_t   sel_s;

    m6809_sync_edge u_sync_e (
        .clk   (HSCLK),
        .rst_n (RST_B),
        .din   (ECLK_LPF),
        .sync  (e_sync_s),
        .rise  (e_rise_s),
        .fall  (e_fall_s)
    );

    m6809_sync_edge u_sync_q (
        .clk   (HSCLK),
        .rst_n (RST_B),
        .din   (QCLK),
        .sync  (q_sync_s),
        .rise  (q_rise_s),
        .fall  (q_fall_s)
    );

    // Q edges and the bus direction are not needed by this block.
    assign sink_unused_s = q_rise_s ^ q_fall_s ^ RNW;

    // Decode of the live bus; it is only ever captured at the IDLE->ACTIVE
    // edge, so the select flops hold the decode of the captured address,
    // DIP and status for the whole cycle.
    assign sel_s = decode_sel(A, DIP, BA, BS);

    // Bus-cycle FSM with registered select / acknowledge outputs.
    // A rise seen while in HOLD (E glitched low and back high) is parked in
    // pend_rise_r so the fall is always honoured with its HOLD cycle first.
    always_ff @(posedge HSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_r     <= ST_IDLE;
            pend_rise_r <= 1'b0;
            csio_r      <= 1'b1;
            csuart_r    <= 1'b1;
            iack_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (e_rise_s || pend_rise_r) begin
                        state_r     <= ST_ACTIVE;
                        pend_rise_r <= 1'b0;
                        csio_r      <= ~sel_s.csio;
                        csuart_r    <= ~sel_s.csuart;
                        iack_r      <= ~sel_s.iack;
                    end else begin
                        state_r     <= ST_IDLE;
                        pend_rise_r <= 1'b0;
                        csio_r      <= 1'b1;
                        csuart_r    <= 1'b1;
                        iack_r      <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (e_fall_s) begin
                        state_r  <= ST_HOLD;
                        csio_r   <= 1'b1;
                        csuart_r <= 1'b1;
                        iack_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_ACTIVE;
                    end
                    pend_rise_r <= 1'b0;
                end
                ST_HOLD: begin
                    state_r     <= ST_IDLE;
                    pend_rise_r <= e_rise_s;
                    csio_r      <= 1'b1;
                    csuart_r    <= 1'b1;
                    iack_r      <= 1'b1;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    pend_rise_r <= 1'b0;
                    csio_r      <= 1'b1;
                    csuart_r    <= 1'b1;
                    iack_r      <= 1'b1;
                end
            endcase
        end
    end

    // Bus grant acknowledge, one HSCLK behind BA/BS.
    always_ff @(posedge HSCLK or negedge RST_B) begin
        if (!RST_B) begin
            busack_r <= 1'b1;
        end else begin
            busack_r <= ~(BA & BS);
        end
    end

    // Next value of the saturating E-fall counter; frozen while E is idle.
    always_comb begin
        cnt_next_s = cnt_r;
        if (e_fall_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Reset-stretch counter and CPC bus reset release.
    always_ff @(posedge HSCLK or negedge RST_B) begin
        if (!RST_B) begin
            cnt_r    <= CNT_ZERO;
            busrst_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            busrst_r <= (cnt_next_s == CNT_MAX);
        end
    end

`ifdef M6809_A8_REMAP_EN
    assign SYS_A8 = A[8] ^ (BS & ~BA);
`else
    assign SYS_A8 = A[8];
`endif

    assign SYS_ECLK     = e_sync_s;
    assign SYS_Q_AUXCLK = q_sync_s;
    assign CSIO_B       = csio_r;
    assign CSUART_B     = csuart_r;
    assign IACK_B       = iack_r;
    assign BUSACK_B     = busack_r;
    assign CPC_BUSRST_B = busrst_r;

endmodule

// File: tb/tb_m6809_glue_ctrl.sv
// tb_m6809_glue_ctrl
// Directed bench for m6809_glue_ctrl. E is driven at HSCLK/4 by hand,
// changing just after an HSCLK rising edge; outputs are sampled 1 time
// unit after each rising edge.
module tb_m6809_glue_ctrl;

    logic        hsclk = 1'b0;
    logic        rst_b;
    logic        eclk_lpf;
    logic        qclk;
    logic [15:5] a;
    logic        ba;
    logic        bs;
    logic        rnw;
    logic [1:0]  dip;
    logic        sys_eclk;
    logic        sys_q_auxclk;
    logic        csio_b;
    logic        csuart_b;
    logic        sys_a8;
    logic        iack_b;
    logic        busack_b;
    logic        cpc_busrst_b;

    int total = 0;
    int bad   = 0;

    m6809_glue_ctrl #(.RST_STRETCH(16)) dut (
        .HSCLK        (hsclk),
        .RST_B        (rst_b),
        .ECLK_LPF     (eclk_lpf),
        .QCLK         (qclk),
        .A            (a),
        .BA           (ba),
        .BS           (bs),
        .RNW          (rnw),
        .DIP          (dip),
        .SYS_ECLK     (sys_eclk),
        .SYS_Q_AUXCLK (sys_q_auxclk),
        .CSIO_B       (csio_b),
        .CSUART_B     (csuart_b),
        .SYS_A8       (sys_a8),
        .IACK_B       (iack_b),
        .BUSACK_B     (busack_b),
        .CPC_BUSRST_B (cpc_busrst_b)
    );

    always #5 hsclk = ~hsclk;

    task automatic tick();
        @(posedge hsclk);
        #1;
    endtask

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic set_addr(input logic [15:0] full);
        logic [15:0] v;
        v = full;
        a = v[15:5];
    endtask

    // One E cycle: pin rise, 2 edges, pin fall, then sample at ACTIVE entry
    // (edge 3), mid-ACTIVE (edge 4, after scrambling A/DIP) and HOLD (edge 5).
    task automatic bus_cycle(input string tag, input logic exp_uart,
                             input logic exp_io, input logic exp_iack);
        eclk_lpf = 1'b1;
        tick();
        tick();
        check({tag, ":pre_uart"}, csuart_b, 1'b1);
        check({tag, ":pre_io"}, csio_b, 1'b1);
        eclk_lpf = 1'b0;
        tick();
        check({tag, ":act_uart"}, csuart_b, exp_uart);
        check({tag, ":act_io"}, csio_b, exp_io);
        check({tag, ":act_iack"}, iack_b, exp_iack);
        a   = 11'h000;
        dip = 2'b01;
        tick();
        check({tag, ":latched_uart"}, csuart_b, exp_uart);
        check({tag, ":latched_io"}, csio_b, exp_io);
        check({tag, ":latched_iack"}, iack_b, exp_iack);
        tick();
        check({tag, ":hold_uart"}, csuart_b, 1'b1);
        check({tag, ":hold_io"}, csio_b, 1'b1);
        check({tag, ":hold_iack"}, iack_b, 1'b1);
        tick();
    endtask

    // 17 E cycles at HSCLK/4; before iteration i's second edge exactly i
    // falls have been processed, so the bus reset must rise at i == 16.
    task automatic stretch_run(input string tag, input int pause_at);
        for (int i = 0; i <= 16; i++) begin
            eclk_lpf = 1'b1;
            tick();
            check($sformatf("%s:cpc_%0d", tag, i), cpc_busrst_b, (i >= 16) ? 1'b1 : 1'b0);
            tick();
            eclk_lpf = 1'b0;
            tick();
            tick();
            if (i == pause_at) begin
                repeat (20) tick();
                check({tag, ":cpc_frozen"}, cpc_busrst_b, 1'b0);
            end
        end
    endtask

    initial begin
        rst_b    = 1'b0;
        eclk_lpf = 1'b0;
        qclk     = 1'b0;
        ba       = 1'b0;
        bs       = 1'b0;
        rnw      = 1'b1;
        dip      = 2'b10;
        set_addr(16'h0000);
        repeat (3) tick();

        check("rst:csio", csio_b, 1'b1);
        check("rst:csuart", csuart_b, 1'b1);
        check("rst:iack", iack_b, 1'b1);
        check("rst:busack", busack_b, 1'b1);
        check("rst:cpc", cpc_busrst_b, 1'b0);
        check("rst:eclk", sys_eclk, 1'b0);
        rst_b = 1'b1;
        tick();

        // Q synchroniser: two edges of latency.
        qclk = 1'b1;
        tick();
        check("q:lat1", sys_q_auxclk, 1'b0);
        tick();
        check("q:lat2", sys_q_auxclk, 1'b1);
        qclk = 1'b0;
        tick();
        tick();

        // Reset stretch from power-up, with E stalled mid-count.
        stretch_run("stretch", 5);
        tick();
        tick();

        // UART window: DIP=10, A=$FE00.
        dip = 2'b10;
        set_addr(16'hFE00);
        check("uart:a8", sys_a8, 1'b0);
        bus_cycle("uart", 1'b0, 1'b1, 1'b1);

        // I/O window $FEA0, then $FCA0 outside the DIP page.
        dip = 2'b10;
        set_addr(16'hFEA0);
        bus_cycle("io_fea0", 1'b1, 1'b0, 1'b1);
        dip = 2'b10;
        set_addr(16'hFCA0);
        bus_cycle("io_fca0", 1'b1, 1'b1, 1'b1);

        // Vector fetch $FFFE: IACK only, A8 remapped when the macro is set.
        dip = 2'b10;
        bs  = 1'b1;
        ba  = 1'b0;
        set_addr(16'hFFFE);
`ifdef M6809_A8_REMAP_EN
        check("vec:a8", sys_a8, 1'b0);
`else
        check("vec:a8", sys_a8, 1'b1);
`endif
        bus_cycle("vec", 1'b1, 1'b1, 1'b0);
        bs = 1'b0;
        tick();

        // Bus grant: BUSACK_B one edge late, no selects even for $FE00.
        ba  = 1'b1;
        bs  = 1'b1;
        dip = 2'b10;
        set_addr(16'hFE00);
        check("grant:busack_pre", busack_b, 1'b1);
        tick();
        check("grant:busack", busack_b, 1'b0);
        bus_cycle("grant", 1'b1, 1'b1, 1'b1);
        ba = 1'b0;
        bs = 1'b0;
        tick();
        check("grant:busack_rel", busack_b, 1'b1);

        // Reset pulled low in the middle of an ACTIVE UART cycle.
        dip = 2'b10;
        set_addr(16'hFE00);
        eclk_lpf = 1'b1;
        tick();
        tick();
        eclk_lpf = 1'b0;
        tick();
        check("midrst:uart_act", csuart_b, 1'b0);
        check("midrst:cpc_before", cpc_busrst_b, 1'b1);
        rst_b = 1'b0;
        #1;
        check("midrst:uart", csuart_b, 1'b1);
        check("midrst:io", csio_b, 1'b1);
        check("midrst:iack", iack_b, 1'b1);
        check("midrst:cpc", cpc_busrst_b, 1'b0);
        tick();
        rst_b = 1'b1;
        tick();
        check("midrst:uart_after", csuart_b, 1'b1);
        stretch_run("restart", 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
